cache_mem_ctrl: RTL and testbench
=================================

# cache_mem_ctrl

Line-transfer controller that shares the single read/write port of the unified 16-bit main memory between the instruction cache and the data cache of the cached CPU. It arbitrates line-fill and write-back requests, then sequences each line as LINE_WORDS single-word memory accesses with a fixed memory latency. It assembles read words into a full line for the requester, and splits write-back lines into words.

## Interface
- WORD_SIZE, 16, memory word and address width
- LINE_WORDS, 4, words per cache line (power of two)
- MEM_LATENCY, 1, cycles from the access strobe to valid mem_rdata (>=1)
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- i_req  in  1  I-cache line-fill request, held until i_done
- i_addr  in  WORD_SIZE  I-side word address; low log2(LINE_WORDS) bits ignored
- i_done  out  1  one-cycle pulse: I-side line in rline valid
- d_req  in  1  D-cache request, held until d_done
- d_we  in  1  1 = write-back of d_wline, 0 = line fill
- d_addr  in  WORD_SIZE  D-side word address; low bits ignored
- d_wline  in  WORD_SIZE*LINE_WORDS  write-back line, word k at bits [16k+15:16k]
- d_done  out  1  one-cycle pulse: D-side transfer complete, rline valid for fills
- rline  out  WORD_SIZE*LINE_WORDS  assembled read line, shared by both sides
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  WORD_SIZE  memory word address
- mem_wdata  out  WORD_SIZE  write data, driven only while mem_write=1; zero otherwise
- mem_rdata  in  WORD_SIZE  memory read data
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: if exactly one req is high, grant it. If both are high, grant the side not granted last (round robin). last_grant resets to I, so the first tie goes to D. On grant, latch the side, the line base address, we (0 for I), and wline. Clear word_cnt. Go to ISSUE.
- ISSUE, one cycle:
  - mem_addr = {base[15:log2 LINE_WORDS], word_cnt}.
  - If we: mem_write=1 and mem_wdata = latched word word_cnt. Else mem_read=1.
  - Load lat_cnt = MEM_LATENCY. Go to WAIT.
- WAIT:
  - Strobes low.
  - lat_cnt decrements each cycle. On its last cycle (lat_cnt==1), a read captures mem_rdata into rline word word_cnt.
  - Then, if word_cnt == LINE_WORDS-1, go to DONE; else increment word_cnt and go to ISSUE.
- DONE, one cycle: pulse the granted side's done, update last_grant, go to IDLE.
- Words are transferred in ascending order 0..LINE_WORDS-1.
- rline holds its value until the next read transaction overwrites it. A write-back leaves rline unchanged.
- Requests are sampled only in IDLE. A request that rises mid-transaction waits.
- If a requester drops req mid-transaction, the transaction still completes and done still pulses.
- Reset, asynchronous, any state:
  - State IDLE, all strobes and done low, mem_addr/mem_wdata/rline zero, counters zero, last_grant = I, busy 0.
  - A partially written line stays partially written in memory; this is accepted.

## Timing
- Cycle 0 = first IDLE cycle with req high.
- First strobe in cycle 1. done is high in cycle 1 + LINE_WORDS*(1+MEM_LATENCY): cycle 9 with defaults, cycle 13 with MEM_LATENCY=2.
- Requester drops req in the cycle after done. The controller is back in IDLE that cycle and can grant the other side in the same cycle, so back-to-back transfers have no idle gap.
- Strobes are never high in consecutive cycles. At most one of mem_read/mem_write is high in any cycle.

## Structure
- Package cache_mem_pkg: WORD_SIZE, LINE_WORDS defaults; state enum {IDLE, ISSUE, WAIT, DONE}; side enum {SIDE_I, SIDE_D}.
- Sub-module mem_rr_arbiter: 2-way round-robin grant.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant.
  - Combinational, used only in IDLE.

## Test plan
- I fill alone, MEM_LATENCY=1, memory words 0x24..0x27 = 6000,f01c,6100,f41c, i_addr=0x25 -> mem_read at 0x24,0x25,0x26,0x27 in cycles 1,3,5,7; i_done in cycle 9; rline = f41c_6100_f01c_6000.
- D write-back, d_addr=0x40, d_wline words 1,2,3,4 -> mem_write in cycles 1,3,5,7 with mem_wdata 1..4; d_done in cycle 9; rline unchanged.
- i_req and d_req raised in the same cycle after reset -> D served first. I is granted in the cycle after d_done, and i_done follows 9 cycles later. A second tie goes to I.
- MEM_LATENCY=2 D fill -> strobes every 3 cycles; d_done in cycle 13; captured words match memory.
- reset_n pulsed low in cycle 4 of a write-back -> all outputs zero immediately. After release, with req held, the transfer restarts from word 0 and d_done occurs 9 cycles after the new grant.
- d_req dropped in cycle 3 -> all 4 words still transferred; d_done still pulses in cycle 9; next IDLE grants nothing.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared types and default sizes for the cache/memory line-transfer controller.
package cache_mem_pkg;
    localparam int DEF_WORD_SIZE  = 16;
    localparam int DEF_LINE_WORDS = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic {SIDE_I, SIDE_D} side_t;
endpackage

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin grant between the I-side (bit 0) and D-side (bit 1).
module mem_rr_arbiter (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);
    // last_grant: 0 = I served last, 1 = D served last; a tie goes to the other side.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/cache_mem_ctrl.sv
// Shares one memory port between I- and D-cache, moving each line as
// LINE_WORDS single-word accesses.
//
// Handshake: a requester raises req (with address/data stable) and holds it
// until its done pulse; requests are sampled only while the controller is idle,
// and a transfer once granted always runs to its done pulse.
module cache_mem_ctrl
    import cache_mem_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int MEM_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             i_req,
    input  logic [WORD_SIZE-1:0]             i_addr,
    output logic                             i_done,
    input  logic                             d_req,
    input  logic                             d_we,
    input  logic [WORD_SIZE-1:0]             d_addr,
    input  logic [WORD_SIZE*LINE_WORDS-1:0]  d_wline,
    output logic                             d_done,
    output logic [WORD_SIZE*LINE_WORDS-1:0]  rline,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic [WORD_SIZE-1:0]             mem_addr,
    output logic [WORD_SIZE-1:0]             mem_wdata,
    input  logic [WORD_SIZE-1:0]             mem_rdata,
    output logic                             busy,
    output logic [1:0]                       state_dbg
);
    localparam int OFS  = $clog2(LINE_WORDS);
    localparam int BW   = WORD_SIZE - OFS;
    localparam int LATW = $clog2(MEM_LATENCY + 1);
    localparam logic [OFS-1:0]  LAST_WORD = OFS'(LINE_WORDS - 1);
    localparam logic [LATW-1:0] LAT_LOAD  = LATW'(MEM_LATENCY);
    localparam logic [LATW-1:0] LAT_ONE   = LATW'(1);

    state_t                          state;
    logic                            side_q;
    logic                            we_q;
    logic                            last_grant;
    logic [BW-1:0]                   base;
    logic [WORD_SIZE*LINE_WORDS-1:0] wline_q;
    logic [OFS-1:0]                  word_cnt;
    logic [OFS-1:0]                  next_cnt;
    logic [LATW-1:0]                 lat_cnt;
    logic [1:0]                      grant;
    logic                            grant_we;
    logic [BW-1:0]                   grant_base;
    logic                            unused_addr_bits;

    mem_rr_arbiter u_arb (
        .req        ({d_req, i_req}),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign next_cnt         = word_cnt + 1'b1;
    assign grant_we         = grant[1] & d_we;
    assign grant_base       = grant[1] ? d_addr[WORD_SIZE-1:OFS] : i_addr[WORD_SIZE-1:OFS];
    assign unused_addr_bits = ^{i_addr[OFS-1:0], d_addr[OFS-1:0]};
    assign busy             = (state != IDLE);
    assign state_dbg        = state;

    // Strobes, address and write data are set on the edge that enters ISSUE,
    // so they are high exactly for the one ISSUE cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            side_q     <= SIDE_I;
            we_q       <= 1'b0;
            last_grant <= SIDE_I;
            base       <= '0;
            wline_q    <= '0;
            word_cnt   <= '0;
            lat_cnt    <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            rline      <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_wdata <= '0;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        side_q    <= grant[1];
                        we_q      <= grant_we;
                        base      <= grant_base;
                        wline_q   <= d_wline;
                        word_cnt  <= '0;
                        mem_addr  <= {grant_base, {OFS{1'b0}}};
                        mem_read  <= ~grant_we;
                        mem_write <= grant_we;
                        mem_wdata <= grant_we ? d_wline[WORD_SIZE-1:0] : '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LAT_ONE) begin
                        if (!we_q) begin
                            rline[word_cnt*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
                        end
                        if (word_cnt == LAST_WORD) begin
                            i_done <= (side_q == SIDE_I);
                            d_done <= (side_q == SIDE_D);
                            state  <= DONE;
                        end else begin
                            word_cnt  <= next_cnt;
                            mem_addr  <= {base, next_cnt};
                            mem_read  <= ~we_q;
                            mem_write <= we_q;
                            mem_wdata <= we_q ? wline_q[next_cnt*WORD_SIZE +: WORD_SIZE] : '0;
                            state     <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    last_grant <= side_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Bench for cache_mem_ctrl: one instance with MEM_LATENCY=1 and one with 2,
// each on its own behavioural memory.
module tb_cache_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_req [2], i_done [2], d_req [2], d_we [2], d_done [2];
    logic        mem_read [2], mem_write [2], busy [2], bd_we [2];
    logic [15:0] i_addr [2], d_addr [2], mem_addr [2], mem_wdata [2], mem_rdata [2];
    logic [15:0] bd_addr [2], bd_data [2];
    logic [63:0] d_wline [2], rline [2];
    logic [1:0]  state_dbg [2];

    int total = 0;
    int bad   = 0;
    logic [15:0] ref_mem [int];
    logic [63:0] last_rline [2];
    logic [15:0] pool [6];

    typedef struct {
        int          g;
        bit          side;
        bit          we;
        logic [15:0] addr;
        logic [63:0] wline;
        logic [63:0] exp_rline;
    } vec_t;
    vec_t tbl [6];

    localparam logic [63:0] L24 = 64'hf41c_6100_f01c_6000;
    localparam logic [63:0] L40 = 64'h0004_0003_0002_0001;
    localparam logic [63:0] L80 = 64'h1111_2222_3333_4444;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = g + 1;
        logic [15:0] mem [65536];
        logic [15:0] pipe [LAT];

        cache_mem_ctrl #(.WORD_SIZE(16), .LINE_WORDS(4), .MEM_LATENCY(LAT)) dut (
            .clk(clk), .reset_n(reset_n),
            .i_req(i_req[g]), .i_addr(i_addr[g]), .i_done(i_done[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wline(d_wline[g]),
            .d_done(d_done[g]), .rline(rline[g]),
            .mem_read(mem_read[g]), .mem_write(mem_write[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
            .busy(busy[g]), .state_dbg(state_dbg[g])
        );

        // Read data appears LAT cycles after the strobe cycle.
        always @(posedge clk) begin
            if (bd_we[g]) mem[bd_addr[g]] <= bd_data[g];
            else if (mem_write[g]) mem[mem_addr[g]] <= mem_wdata[g];
            pipe[0] <= mem_read[g] ? mem[mem_addr[g]] : 16'h0;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input int g, input logic [15:0] a, input logic [15:0] d);
        bd_addr[g] = a;
        bd_data[g] = d;
        bd_we[g]   = 1'b1;
        step();
        bd_we[g]   = 1'b0;
        ref_mem[g*65536 + int'(a)] = d;
    endtask

    function automatic logic [63:0] ref_line(input int g, input logic [15:0] a);
        logic [63:0] l;
        for (int k = 0; k < 4; k++) l[16*k +: 16] = ref_mem[g*65536 + int'({a[15:2], 2'(k)})];
        return l;
    endfunction

    task automatic check_reset_outputs(input int g, input string nm);
        check({nm, " ctrl"}, {25'd0, i_done[g], d_done[g], mem_read[g], mem_write[g], busy[g],
                              state_dbg[g], mem_addr[g], mem_wdata[g]}, 64'd0);
        check({nm, " rline"}, rline[g], 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check_reset_outputs(0, "reset0");
        check_reset_outputs(1, "reset1");
        step();
        reset_n = 1'b1;
        last_rline[0] = '0;
        last_rline[1] = '0;
    endtask

    // Called #1 after an edge with the DUT idle; that cycle is cycle 0.
    task automatic run_xfer(input int g, input bit side, input bit we, input logic [15:0] addr,
                            input logic [63:0] wline, input int drop_at,
                            input logic [63:0] exp_rline, input string nm);
        int per, exp_done, done_at, n, k, errs;
        bit is_str;
        logic [15:0] exp_wd;
        per      = 2 + g;
        exp_done = 1 + 4 * per;
        done_at  = -1;
        n        = 0;
        errs     = 0;
        if (!side) begin
            i_req[g] = 1'b1; i_addr[g] = addr;
        end else begin
            d_req[g] = 1'b1; d_we[g] = we; d_addr[g] = addr; d_wline[g] = wline;
        end
        while (n < 60 && done_at < 0) begin
            step();
            n++;
            is_str = ((n - 1) % per == 0) && (n <= 4 * per);
            k      = (n - 1) / per;
            exp_wd = (is_str && we) ? wline[16*k +: 16] : 16'h0;
            if (mem_read[g] !== (is_str && !we) || mem_write[g] !== (is_str && we)) errs++;
            if (is_str && mem_addr[g] !== {addr[15:2], k[1:0]}) errs++;
            if (mem_wdata[g] !== exp_wd) errs++;
            if (busy[g] !== 1'b1) errs++;
            if (n == drop_at) begin
                i_req[g] = 1'b0; d_req[g] = 1'b0;
            end
            if ((side ? i_done[g] : d_done[g]) !== 1'b0) errs++;
            if ((side ? d_done[g] : i_done[g]) === 1'b1) done_at = n;
        end
        i_req[g] = 1'b0;
        d_req[g] = 1'b0;
        check({nm, " done_cycle"}, 64'(done_at), 64'(exp_done));
        check({nm, " strobe_errs"}, 64'(errs), 64'd0);
        check({nm, " rline"}, rline[g], exp_rline);
        step();
        check({nm, " idle_after"}, {61'd0, busy[g], i_done[g], d_done[g]}, 64'd0);
        if (we) begin
            for (int j = 0; j < 4; j++) ref_mem[g*65536 + int'({addr[15:2], 2'(j)})] = wline[16*j +: 16];
        end else begin
            last_rline[g] = exp_rline;
        end
    endtask

    // Both sides request in the same cycle on instance 0 (I fills 0x24, D fills 0x40).
    task automatic tie_run(input int exp_i_at, input int exp_d_at, input string nm);
        int n, i_at, d_at;
        i_req[0] = 1'b1; i_addr[0] = 16'h0024;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0040;
        n = 0; i_at = -1; d_at = -1;
        while (n < 60 && (i_at < 0 || d_at < 0)) begin
            step();
            n++;
            if (i_done[0] === 1'b1) begin
                i_at = n; i_req[0] = 1'b0;
                check({nm, " i_rline"}, rline[0], L24);
            end
            if (d_done[0] === 1'b1) begin
                d_at = n; d_req[0] = 1'b0;
                check({nm, " d_rline"}, rline[0], L40);
            end
        end
        i_req[0] = 1'b0;
        d_req[0] = 1'b0;
        check({nm, " i_done_cycle"}, 64'(i_at), 64'(exp_i_at));
        check({nm, " d_done_cycle"}, 64'(d_at), 64'(exp_d_at));
        step();
        last_rline[0] = (exp_i_at > exp_d_at) ? L24 : L40;
    endtask

    initial begin
        int g, n;
        bit side, we;
        logic [15:0] a;
        logic [63:0] wl, exp;

        for (int i = 0; i < 2; i++) begin
            i_req[i] = 0; d_req[i] = 0; d_we[i] = 0; bd_we[i] = 0;
            i_addr[i] = 0; d_addr[i] = 0; d_wline[i] = 0; bd_addr[i] = 0; bd_data[i] = 0;
        end
        reset_n = 1'b1;
        step();
        do_reset();

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 4; k++) bd_write(i, 16'h0024 + 16'(k), L24[16*k +: 16]);
        end

        tbl[0] = '{0, 1'b0, 1'b0, 16'h0025, 64'd0, L24};
        tbl[1] = '{0, 1'b1, 1'b1, 16'h0040, L40, L24};
        tbl[2] = '{0, 1'b1, 1'b0, 16'h0043, 64'd0, L40};
        tbl[3] = '{1, 1'b1, 1'b0, 16'h0026, 64'd0, L24};
        tbl[4] = '{1, 1'b1, 1'b1, 16'h0040, 64'haaaa_bbbb_cccc_dddd, L24};
        tbl[5] = '{1, 1'b0, 1'b0, 16'h0041, 64'd0, 64'haaaa_bbbb_cccc_dddd};
        for (int i = 0; i < 6; i++) begin
            run_xfer(tbl[i].g, tbl[i].side, tbl[i].we, tbl[i].addr, tbl[i].wline, -1,
                     tbl[i].exp_rline, $sformatf("vec%0d", i));
        end

        // First tie after reset goes to D, I follows without a gap; after a D
        // transfer the next tie goes to I.
        do_reset();
        tie_run(19, 9, "tie1");
        run_xfer(0, 1'b1, 1'b1, 16'h0040, L40, -1, L24, "tie_mid_wb");
        tie_run(9, 19, "tie2");

        // Reset during word 1 of a write-back, then restart with req held.
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 16'h0080; d_wline[0] = L80;
        for (int c = 0; c < 4; c++) step();
        reset_n = 1'b0;
        #1;
        check_reset_outputs(0, "midrst0");
        check_reset_outputs(1, "midrst1");
        reset_n = 1'b1;
        last_rline[0] = '0;
        last_rline[1] = '0;
        run_xfer(0, 1'b1, 1'b1, 16'h0080, L80, -1, 64'd0, "restart_wb");

        // Requester drops req in cycle 3; the fill still completes.
        run_xfer(0, 1'b1, 1'b0, 16'h0082, 64'd0, 3, L80, "drop");
        step();
        check("drop no_regrant", {63'd0, busy[0]}, 64'd0);

        for (int j = 0; j < 6; j++) pool[j] = 16'($urandom_range(0, 16'hffff)) & 16'hfffc;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 6; j++) begin
                for (int k = 0; k < 4; k++) bd_write(i, pool[j] | 16'(k), 16'($urandom));
            end
        end
        for (int t = 0; t < 24; t++) begin
            g    = $urandom_range(0, 1);
            side = 1'($urandom_range(0, 1));
            we   = side ? 1'($urandom_range(0, 1)) : 1'b0;
            a    = pool[$urandom_range(0, 5)] | 16'($urandom_range(0, 3));
            wl   = {$urandom, $urandom};
            exp  = we ? last_rline[g] : ref_line(g, a);
            n    = $urandom_range(0, 8);
            run_xfer(g, side, we, a, wl, (n == 0) ? 2 : -1, exp, $sformatf("rand%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
